// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN,
    MUL_WAIT,
    MEM_WAIT
  } state_e;

  localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/hazard_control_sat_counter.sv
// Saturating up-counter used for the stall and flush statistics.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_control.sv
// Hazard sequencing for the 5-stage core: load-use stall, branch
// squash, multi-cycle multiply hold and data-memory freeze.
module hazard_control
  import hazard_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int STALL_CNT_W = 16,
  parameter int FLUSH_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             IFIDrn,
  input  logic [4:0]             IFIDrm,
  input  logic                   IFIDusesrm,
  input  logic                   IDEXmemread,
  input  logic [4:0]             IDEXrd,
  input  logic                   IDEXmul,
  input  logic                   branch_taken,
  input  logic                   dmem_req,
  input  logic                   dmem_ready,
  output logic                   pc_write,
  output logic                   ifid_write,
  output logic                   ifid_flush,
  output logic                   idex_hold,
  output logic                   idex_bubble,
  output logic                   exmem_hold,
  output logic                   exmem_bubble,
  output logic                   memwb_bubble,
  output logic                   mul_start,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic [FLUSH_CNT_W-1:0] flush_count
);

  localparam logic [3:0] MUL_LOAD =
    4'(MUL_LATENCY > 1 ? MUL_LATENCY - 2 : 0);

  state_e     state_q, state_d;
  logic [3:0] mul_cnt_q, mul_cnt_d;
  logic       mem_wait;
  logic       load_use;
  logic       mul_stall;

  assign mem_wait = dmem_req && !dmem_ready;
  assign load_use = IDEXmemread && (IDEXrd != XZR) &&
    ((IDEXrd == IFIDrn) || (IFIDusesrm && (IDEXrd == IFIDrm)));
  assign mul_stall = IDEXmul && (MUL_LATENCY > 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      mul_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mul_cnt_d    = mul_cnt_q;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_hold    = 1'b0;
    idex_bubble  = 1'b0;
    exmem_hold   = 1'b0;
    exmem_bubble = 1'b0;
    memwb_bubble = 1'b0;
    mul_start    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_wait) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_hold    = 1'b1;
          exmem_hold   = 1'b1;
          memwb_bubble = 1'b1;
          state_d      = MEM_WAIT;
        end else if (mul_stall) begin
          mul_start    = 1'b1;
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_hold    = 1'b1;
          exmem_bubble = 1'b1;
          mul_cnt_d    = MUL_LOAD;
          state_d      = MUL_WAIT;
        end else begin
          // Single-cycle multiply only pulses start, then acts as RUN.
          mul_start = IDEXmul;
          if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end
      end
      MUL_WAIT: begin
        if (mul_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_hold    = 1'b1;
          exmem_bubble = 1'b1;
          mul_cnt_d    = mul_cnt_q - 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
        end else begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_hold    = 1'b1;
          exmem_hold   = 1'b1;
          memwb_bubble = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    if (!rst_n) begin
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      ifid_flush   = 1'b0;
      idex_hold    = 1'b0;
      idex_bubble  = 1'b0;
      exmem_hold   = 1'b0;
      exmem_bubble = 1'b0;
      memwb_bubble = 1'b0;
      mul_start    = 1'b0;
    end
  end

  sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (~pc_write),
    .count_o (stall_count)
  );

  sat_counter #(.W(FLUSH_CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (ifid_flush),
    .count_o (flush_count)
  );

endmodule

// File: tb/tb_hazard_control.sv
// Randomised and directed bench for hazard_control against a
// cycle-level behavioural model of the hazard rules.
module tb_hazard_control;

  localparam int L    = 4;
  localparam int SMAX = 65535;
  localparam int FMAX = 255;

  logic        clk;
  logic        rst_n;
  logic [4:0]  IFIDrn, IFIDrm, IDEXrd;
  logic        IFIDusesrm, IDEXmemread, IDEXmul;
  logic        branch_taken, dmem_req, dmem_ready;
  logic        pc_write, ifid_write, ifid_flush;
  logic        idex_hold, idex_bubble, exmem_hold;
  logic        exmem_bubble, memwb_bubble, mul_start;
  logic [15:0] stall_count;
  logic [7:0]  flush_count;

  hazard_control #(
    .MUL_LATENCY (L),
    .STALL_CNT_W (16),
    .FLUSH_CNT_W (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .IFIDrn       (IFIDrn),
    .IFIDrm       (IFIDrm),
    .IFIDusesrm   (IFIDusesrm),
    .IDEXmemread  (IDEXmemread),
    .IDEXrd       (IDEXrd),
    .IDEXmul      (IDEXmul),
    .branch_taken (branch_taken),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_hold    (idex_hold),
    .idex_bubble  (idex_bubble),
    .exmem_hold   (exmem_hold),
    .exmem_bubble (exmem_bubble),
    .memwb_bubble (memwb_bubble),
    .mul_start    (mul_start),
    .stall_count  (stall_count),
    .flush_count  (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: memory freeze flag, cycles the current multiply has
  // already spent in EX (0 = none in flight), and event counters.
  bit m_mem;
  int m_age;
  int m_stall;
  int m_flush;
  bit e_pc, e_ifw, e_iff, e_idh, e_idb, e_exh, e_exb, e_mwb, e_ms;
  bit lu;

  task automatic freeze_mem();
    e_pc = 0; e_ifw = 0; e_idh = 1; e_exh = 1; e_mwb = 1;
  endtask

  task automatic hold_mul();
    e_pc = 0; e_ifw = 0; e_idh = 1; e_exb = 1;
  endtask

  always @(negedge clk) begin
    e_pc = 1; e_ifw = 1; e_iff = 0; e_idh = 0; e_idb = 0;
    e_exh = 0; e_exb = 0; e_mwb = 0; e_ms = 0;
    if (!rst_n) begin
      m_mem = 0;
      m_age = 0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      lu = IDEXmemread && IDEXrd != 5'd31 &&
        (IDEXrd == IFIDrn || (IFIDusesrm && IDEXrd == IFIDrm));
      if (m_mem) begin
        if (!dmem_ready) freeze_mem();
        else m_mem = 0;
      end else if (m_age > 0) begin
        check("dmem_req_in_mul", int'(dmem_req), 0);
        if (m_age + 1 == L) m_age = 0;
        else begin
          hold_mul();
          m_age++;
        end
      end else if (dmem_req && !dmem_ready) begin
        freeze_mem();
        m_mem = 1;
      end else if (IDEXmul && L > 1) begin
        e_ms = 1;
        hold_mul();
        m_age = 1;
      end else begin
        e_ms = IDEXmul;
        if (branch_taken) begin
          e_iff = 1; e_idb = 1;
        end else if (lu) begin
          e_pc = 0; e_ifw = 0; e_idb = 1;
        end
      end
    end
    check("pc_write", int'(pc_write), int'(e_pc));
    check("ifid_write", int'(ifid_write), int'(e_ifw));
    check("ifid_flush", int'(ifid_flush), int'(e_iff));
    check("idex_hold", int'(idex_hold), int'(e_idh));
    check("idex_bubble", int'(idex_bubble), int'(e_idb));
    check("exmem_hold", int'(exmem_hold), int'(e_exh));
    check("exmem_bubble", int'(exmem_bubble), int'(e_exb));
    check("memwb_bubble", int'(memwb_bubble), int'(e_mwb));
    check("mul_start", int'(mul_start), int'(e_ms));
    check("stall_count", int'(stall_count), m_stall);
    check("flush_count", int'(flush_count), m_flush);
    if (rst_n) begin
      if (!e_pc && m_stall < SMAX) m_stall++;
      if (e_iff && m_flush < FMAX) m_flush++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    IFIDrn = 5'd0; IFIDrm = 5'd0; IFIDusesrm = 0;
    IDEXmemread = 0; IDEXrd = 5'd0; IDEXmul = 0;
    branch_taken = 0; dmem_req = 0; dmem_ready = 1;
  endtask

  function automatic logic [4:0] pick();
    int r;
    r = int'($urandom_range(0, 4));
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  int n_a, n_b, n_c;

  initial begin
    rst_n = 0;
    idle();
    #1;
    check("rst_pc_write", int'(pc_write), 1);
    check("rst_ifid_write", int'(ifid_write), 1);
    check("rst_idex_bubble", int'(idex_bubble), 0);
    check("rst_stall_count", int'(stall_count), 0);
    check("rst_flush_count", int'(flush_count), 0);
    tick();
    tick();
    rst_n = 1;

    // Load-use on Rn.
    IDEXmemread = 1; IDEXrd = 5'd2; IFIDrn = 5'd2;
    at_neg();
    check("lu_pc_write", int'(pc_write), 0);
    check("lu_idex_bubble", int'(idex_bubble), 1);
    tick();
    idle();
    at_neg();
    check("lu_stall_count", int'(stall_count), 1);
    check("lu_released", int'(pc_write), 1);

    // XZR and unused Rm never stall.
    tick();
    IDEXmemread = 1; IDEXrd = 5'd31; IFIDrn = 5'd31;
    at_neg();
    check("xzr_no_stall", int'(pc_write), 1);
    tick();
    IDEXrd = 5'd2; IFIDrn = 5'd5; IFIDrm = 5'd2; IFIDusesrm = 0;
    at_neg();
    check("rm_unused_no_stall", int'(pc_write), 1);

    // Branch beats load-use.
    tick();
    IFIDrn = 5'd2; branch_taken = 1;
    at_neg();
    check("br_ifid_flush", int'(ifid_flush), 1);
    check("br_idex_bubble", int'(idex_bubble), 1);
    check("br_pc_write", int'(pc_write), 1);
    tick();
    idle();
    at_neg();
    check("br_flush_count", int'(flush_count), 1);
    check("br_stall_count", int'(stall_count), 1);

    // Multiply occupies EX for L cycles.
    tick();
    IDEXmul = 1;
    n_a = 0; n_b = 0; n_c = 0;
    for (int i = 0; i < L; i++) begin
      at_neg();
      n_a += int'(mul_start);
      n_b += int'(!pc_write);
      n_c += int'(exmem_bubble);
      tick();
    end
    idle();
    check("mul_start_pulses", n_a, 1);
    check("mul_stall_cycles", n_b, 3);
    check("mul_exmem_bubbles", n_c, 3);
    at_neg();
    check("mul_stall_count", int'(stall_count), 4);

    // Memory freeze with a pending branch.
    tick();
    dmem_req = 1; dmem_ready = 0; branch_taken = 1;
    n_a = 0;
    for (int i = 0; i < 5; i++) begin
      at_neg();
      n_a += int'(!pc_write && memwb_bubble && idex_hold && exmem_hold);
      tick();
    end
    check("mem_freeze_cycles", n_a, 5);
    dmem_ready = 1;
    at_neg();
    check("mem_release_no_flush", int'(ifid_flush), 0);
    check("mem_release_pc", int'(pc_write), 1);
    tick();
    dmem_req = 0;
    at_neg();
    check("mem_then_flush", int'(ifid_flush), 1);
    tick();
    idle();
    at_neg();
    check("mem_stall_count", int'(stall_count), 9);
    check("mem_flush_count", int'(flush_count), 2);

    // Random traffic, constrained to legal combinations.
    for (int i = 0; i < 3000; i++) begin
      tick();
      IFIDrn = pick(); IFIDrm = pick(); IDEXrd = pick();
      IFIDusesrm = 1'($urandom % 2);
      IDEXmemread = 1'($urandom % 2);
      dmem_ready = 1'($urandom % 2);
      if (m_age > 0) begin
        IDEXmul = 1; branch_taken = 0; dmem_req = 0;
      end else begin
        IDEXmul = ($urandom % 6) == 0;
        branch_taken = !IDEXmul && (($urandom % 5) == 0);
        dmem_req = ($urandom % 4) == 0;
      end
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      idle();
    end

    // Stall counter saturation.
    IDEXmemread = 1; IDEXrd = 5'd1; IFIDrn = 5'd1;
    for (int i = 0; i < 70000; i++) tick();
    idle();
    at_neg();
    check("stall_saturated", int'(stall_count), SMAX);

    // Asynchronous reset in the middle of a multiply.
    tick();
    IDEXmul = 1;
    tick();
    check("mul_wait_stalled", int'(pc_write), 0);
    #2;
    rst_n = 0;
    #1;
    check("arst_pc_write", int'(pc_write), 1);
    check("arst_idex_hold", int'(idex_hold), 0);
    check("arst_exmem_bubble", int'(exmem_bubble), 0);
    check("arst_mul_start", int'(mul_start), 0);
    check("arst_stall_count", int'(stall_count), 0);
    check("arst_flush_count", int'(flush_count), 0);
    tick();
    rst_n = 1;
    IDEXmul = 0;
    at_neg();
    check("post_rst_run", int'(pc_write), 1);
    check("post_rst_no_hold", int'(idex_hold), 0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
